// File: rtl/ans_display_if.sv
// Link between the arithmetic result producer and the seven-segment display back-end.
// The arithmetic side drives ans/signed_mode/load; the display side returns busy and the drive pins.
interface ans_display_if;
    logic [15:0] ans;
    logic        signed_mode;
    logic        load;
    logic        busy;
    logic [7:0]  digit_en;
    logic [6:0]  segments;
    logic        dp;

    modport master (
        output ans,
        output signed_mode,
        output load,
        input  busy,
        input  digit_en,
        input  segments,
        input  dp
    );

    modport slave (
        input  ans,
        input  signed_mode,
        input  load,
        output busy,
        output digit_en,
        output segments,
        output dp
    );
endinterface

// File: rtl/ans_display.sv
// Captures a 16-bit result, converts it to sign-magnitude BCD by sequential double-dabble,
// and scans it onto an 8-digit active-low multiplexed seven-segment display.
module ans_display #(
    parameter int CLK_DIV = 100000
) (
    input  logic          clock,
    input  logic          reset,
    ans_display_if.slave  bus
);
    localparam int              DIV_W     = $clog2(CLK_DIV);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
    localparam logic [6:0]      SEG_BLANK = 7'b1111111;
    localparam logic [6:0]      SEG_MINUS = 7'b0111111;

    typedef enum logic [1:0] {IDLE, CONV, UPDATE} state_t;

    state_t             state;
    logic               busy;
    logic [3:0]         iter;
    logic [15:0]        mag;
    logic [19:0]        bcd;
    logic               neg_cap;
    logic [19:0]        disp_bcd;
    logic               disp_neg;
    logic [DIV_W-1:0]   div_cnt;
    logic [2:0]         idx;
    logic [7:0]         digit_en;
    logic [6:0]         segments;

    logic signed [15:0] ans_s;
    logic               neg_in;
    logic [35:0]        dabble_shift;
    logic [19:0]        upper;
    logic [6:0]         seg_next;

    function automatic logic [19:0] dabble_adj(input logic [19:0] b);
        logic [19:0] r;
        r = b;
        for (int i = 0; i < 5; i++) begin
            if (b[4*i +: 4] >= 4'd5)
                r[4*i +: 4] = b[4*i +: 4] + 4'd3;
        end
        return r;
    endfunction

    function automatic logic [6:0] seg_of(input logic [3:0] n);
        case (n)
            4'd0:    return 7'b1000000;
            4'd1:    return 7'b1111001;
            4'd2:    return 7'b0100100;
            4'd3:    return 7'b0110000;
            4'd4:    return 7'b0011001;
            4'd5:    return 7'b0010010;
            4'd6:    return 7'b0000010;
            4'd7:    return 7'b1111000;
            4'd8:    return 7'b0000000;
            4'd9:    return 7'b0010000;
            default: return SEG_BLANK;
        endcase
    endfunction

    assign ans_s        = signed'(bus.ans);
    assign neg_in       = bus.signed_mode & bus.ans[15];
    assign dabble_shift = {dabble_adj(bcd), mag} << 1;

    // Conversion control; the display registers only change in UPDATE, so a
    // reset mid-conversion can never leak a partial result.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state    <= IDLE;
            busy     <= 1'b0;
            iter     <= 4'd0;
            disp_bcd <= 20'd0;
            disp_neg <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.load) begin
                        state <= CONV;
                        busy  <= 1'b1;
                        iter  <= 4'd0;
                    end
                end
                CONV: begin
                    iter <= iter + 4'd1;
                    if (iter == 4'd15)
                        state <= UPDATE;
                end
                UPDATE: begin
                    disp_bcd <= bcd;
                    disp_neg <= neg_cap;
                    busy     <= 1'b0;
                    state    <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Double-dabble datapath: magnitude shifts out MSB-first into the BCD accumulator.
    always_ff @(posedge clock) begin
        if (state == IDLE && bus.load) begin
            mag     <= neg_in ? unsigned'(-ans_s) : bus.ans;
            neg_cap <= neg_in;
            bcd     <= 20'd0;
        end else if (state == CONV) begin
            bcd <= dabble_shift[35:16];
            mag <= dabble_shift[15:0];
        end
    end

    assign upper = disp_bcd >> {idx, 2'b00};

    // Digit i>0 blanks when it and every more significant digit are zero.
    always_comb begin
        seg_next = SEG_BLANK;
        if (idx <= 3'd4) begin
            if (idx == 3'd0 || upper != 20'd0)
                seg_next = seg_of(upper[3:0]);
        end else if (idx == 3'd7 && disp_neg) begin
            seg_next = SEG_MINUS;
        end
    end

    // Free-running scan, independent of the conversion FSM.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            div_cnt  <= '0;
            idx      <= 3'd0;
            digit_en <= 8'hFE;
            segments <= 7'b1000000;
        end else begin
            if (div_cnt == DIV_LAST) begin
                div_cnt <= '0;
                idx     <= idx + 3'd1;
            end else begin
                div_cnt <= div_cnt + 1'b1;
            end
            digit_en <= ~(8'd1 << idx);
            segments <= seg_next;
        end
    end

    assign bus.busy     = busy;
    assign bus.digit_en = digit_en;
    assign bus.segments = segments;
    assign bus.dp       = 1'b1;

endmodule

// File: tb/tb_ans_display.sv
// Directed bench for ans_display: reset, scan rotation, conversions, ignored load, reset abort.
module tb_ans_display;
    localparam logic [6:0] S0 = 7'b1000000, S1 = 7'b1111001, S2 = 7'b0100100,
                           S3 = 7'b0110000, S4 = 7'b0011001, S5 = 7'b0010010,
                           S6 = 7'b0000010, S7 = 7'b1111000, S8 = 7'b0000000,
                           S9 = 7'b0010000, SB = 7'b1111111, SM = 7'b0111111;

    logic clock = 1'b0;
    logic reset = 1'b1;
    int   total = 0;
    int   passed = 0;
    logic [6:0] shown [8];
    logic [6:0] exp_seg [8];

    ans_display_if bus();

    ans_display #(.CLK_DIV(4)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clock = ~clock;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic pulse_load(input logic [15:0] a, input logic sm);
        @(negedge clock);
        bus.ans = a;
        bus.signed_mode = sm;
        bus.load = 1'b1;
        @(negedge clock);
        bus.load = 1'b0;
    endtask

    task automatic capture_display();
        logic [7:0] sel;
        for (int i = 0; i < 8; i++) shown[i] = 7'bx;
        for (int t = 0; t < 40; t++) begin
            @(negedge clock);
            for (int i = 0; i < 8; i++) begin
                sel = ~(8'd1 << i);
                if (bus.digit_en == sel) shown[i] = bus.segments;
            end
        end
    endtask

    task automatic run_conversion(input logic [15:0] a, input logic sm, input string name);
        int n;
        pulse_load(a, sm);
        n = 0;
        while (bus.busy && n < 100) begin
            n++;
            @(negedge clock);
        end
        total++;
        if (n !== 17) $display("FAIL %s_busy_cycles: got %0d expected 17", name, n);
        else passed++;
        capture_display();
        for (int i = 0; i < 8; i++) begin
            total++;
            if (shown[i] !== exp_seg[i])
                $display("FAIL %s_digit%0d: got %b expected %b", name, i, shown[i], exp_seg[i]);
            else passed++;
        end
    endtask

    task automatic test_reset();
        logic [7:0] de [48];
        int run;
        bit seen;
        bit wrap;
        #1 reset = 1'b0;
        @(negedge clock);
        @(negedge clock);
        total++; if (bus.digit_en !== 8'hFE) $display("FAIL reset_digit_en: got %h expected fe", bus.digit_en); else passed++;
        total++; if (bus.segments !== S0) $display("FAIL reset_segments: got %b expected %b", bus.segments, S0); else passed++;
        total++; if (bus.busy !== 1'b0) $display("FAIL reset_busy: got %b expected 0", bus.busy); else passed++;
        total++; if (bus.dp !== 1'b1) $display("FAIL reset_dp: got %b expected 1", bus.dp); else passed++;
        reset = 1'b1;
        for (int t = 0; t < 48; t++) begin
            @(negedge clock);
            de[t] = bus.digit_en;
        end
        run = 0; seen = 0; wrap = 0;
        for (int t = 1; t < 48; t++) begin
            run++;
            if (de[t] != de[t-1]) begin
                if (seen) begin
                    total++;
                    if (run !== 4) $display("FAIL scan_dwell: got %0d cycles expected 4", run);
                    else passed++;
                end
                total++;
                if (de[t] !== {de[t-1][6:0], de[t-1][7]})
                    $display("FAIL scan_rotate: got %h after %h", de[t], de[t-1]);
                else passed++;
                if (de[t-1] == 8'h7F && de[t] == 8'hFE) wrap = 1;
                seen = 1;
                run = 0;
            end
        end
        total++;
        if (wrap !== 1'b1) $display("FAIL scan_wrap: got %b expected 1", wrap); else passed++;
    endtask

    task automatic test_unsigned();
        exp_seg = '{S5, S2, S2, SB, SB, SB, SB, SB};
        run_conversion(16'd225, 1'b0, "u225");
        exp_seg = '{S5, S3, S5, S5, S6, SB, SB, SB};
        run_conversion(16'hFFFF, 1'b0, "u65535");
    endtask

    task automatic test_signed();
        exp_seg = '{S3, S1, SB, SB, SB, SB, SB, SM};
        run_conversion(16'hFFF3, 1'b1, "s_m13");
        exp_seg = '{S8, S6, S7, S2, S3, SB, SB, SM};
        run_conversion(16'h8000, 1'b1, "s_m32768");
    endtask

    task automatic test_ignored_load();
        int n;
        pulse_load(16'd42, 1'b0);
        n = 0;
        while (bus.busy && n < 100) begin
            n++;
            if (n == 5) begin
                bus.ans = 16'd99;
                bus.load = 1'b1;
            end else begin
                bus.load = 1'b0;
            end
            @(negedge clock);
        end
        bus.load = 1'b0;
        total++;
        if (n !== 17) $display("FAIL ignored_busy_cycles: got %0d expected 17", n); else passed++;
        repeat (3) @(negedge clock);
        total++;
        if (bus.busy !== 1'b0) $display("FAIL ignored_not_queued: got busy %b expected 0", bus.busy); else passed++;
        capture_display();
        exp_seg = '{S2, S4, SB, SB, SB, SB, SB, SB};
        for (int i = 0; i < 8; i++) begin
            total++;
            if (shown[i] !== exp_seg[i])
                $display("FAIL ignored_digit%0d: got %b expected %b", i, shown[i], exp_seg[i]);
            else passed++;
        end
    endtask

    task automatic test_reset_abort();
        int highs;
        exp_seg = '{S7, SB, SB, SB, SB, SB, SB, SB};
        run_conversion(16'd7, 1'b0, "pre7");
        pulse_load(16'd12345, 1'b0);
        repeat (7) @(negedge clock);
        total++;
        if (bus.busy !== 1'b1) $display("FAIL abort_busy_before: got %b expected 1", bus.busy); else passed++;
        #2 reset = 1'b0;
        #1;
        total++; if (bus.digit_en !== 8'hFE) $display("FAIL abort_digit_en: got %h expected fe", bus.digit_en); else passed++;
        total++; if (bus.segments !== S0) $display("FAIL abort_segments: got %b expected %b", bus.segments, S0); else passed++;
        total++; if (bus.busy !== 1'b0) $display("FAIL abort_busy: got %b expected 0", bus.busy); else passed++;
        @(negedge clock);
        reset = 1'b1;
        highs = 0;
        for (int t = 0; t < 30; t++) begin
            @(negedge clock);
            if (bus.busy) highs++;
        end
        total++;
        if (highs !== 0) $display("FAIL abort_no_restart: got %0d busy cycles expected 0", highs); else passed++;
        capture_display();
        exp_seg = '{S0, SB, SB, SB, SB, SB, SB, SB};
        for (int i = 0; i < 8; i++) begin
            total++;
            if (shown[i] !== exp_seg[i])
                $display("FAIL abort_digit%0d: got %b expected %b", i, shown[i], exp_seg[i]);
            else passed++;
        end
    endtask

    initial begin
        bus.ans = 16'd0;
        bus.signed_mode = 1'b0;
        bus.load = 1'b0;
        test_reset();
        test_unsigned();
        test_signed();
        test_ignored_load();
        test_reset_abort();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
